// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - multi-cycle ALU op sequencer driving decode controls and accumulator/flag strobes
// Optional: ALU_SEQ_BARREL_EN selects single-cycle barrel shifts instead of iterative 1-bit shifting.
module alu_op_sequencer #(
  parameter int DATA_W  = 8,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [2:0]         FS,
  input  logic [SHAMT_W-1:0] SHAMT,
  output logic               BSEL,
  output logic               CISEL,
  output logic [1:0]         OSEL,
  output logic               SHIFT_LA,
  output logic               SHIFT_LR,
  output logic               LOGICAL_OA,
  output logic [1:0]         CSEL,
  output logic [SHAMT_W-1:0] SHAMT_OUT,
  output logic               ACC_LOAD,
  output logic               ACC_WE,
  output logic               FLAG_WE,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic               ERR
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] FS_ADD = 3'b000;
  localparam logic [2:0] FS_SUB = 3'b001;
  localparam logic [2:0] FS_SRA = 3'b010;
  localparam logic [2:0] FS_SRL = 3'b011;
  localparam logic [2:0] FS_SLL = 3'b100;
  localparam logic [2:0] FS_AND = 3'b101;
  localparam logic [2:0] FS_OR  = 3'b110;
  localparam logic [2:0] FS_ILL = 3'b111;

  localparam logic [1:0] OSEL_ADDER = 2'd0;
  localparam logic [1:0] OSEL_SHIFT = 2'd1;
  localparam logic [1:0] OSEL_LOGIC = 2'd2;
  localparam logic [1:0] CSEL_ADDER = 2'd0;
  localparam logic [1:0] CSEL_ZERO  = 2'd1;
  localparam logic [1:0] CSEL_SHIFT = 2'd2;

  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  logic [1:0]         r_state;
  logic [2:0]         r_fs;
  logic [SHAMT_W-1:0] r_shamt;
  logic [SHAMT_W-1:0] r_cnt;
  logic               r_err;

  logic               w_accept;
  logic               w_is_shift;
  logic               w_shamt_zero;
  logic               w_last;
  logic [SHAMT_W-1:0] w_load_cnt;
  logic [SHAMT_W-1:0] w_exec_shamt;

  assign w_accept     = IN_VALID && (r_state == S_IDLE);
  assign w_is_shift   = (r_fs == FS_SRA) || (r_fs == FS_SRL) || (r_fs == FS_SLL);
  assign w_shamt_zero = (r_shamt == '0);
  assign w_last       = (r_cnt == CNT_ONE);

`ifdef ALU_SEQ_BARREL_EN
  // The datapath shifts the full distance in one pass, so every op gets one EXEC cycle.
  assign w_load_cnt   = CNT_ONE;
  assign w_exec_shamt = r_shamt;
`else
  assign w_load_cnt   = (w_is_shift && !w_shamt_zero) ? r_shamt : CNT_ONE;
  assign w_exec_shamt = CNT_ONE;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_fs    <= FS_ADD;
      r_shamt <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_fs    <= FS;
            r_shamt <= SHAMT;
            r_err   <= (FS == FS_ILL);
            r_state <= (FS == FS_ILL) ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: begin
          r_cnt   <= w_load_cnt;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_cnt <= r_cnt - CNT_ONE;
          if (w_last) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (OUT_READY) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign IN_READY  = (r_state == S_IDLE);
  assign ACC_LOAD  = (r_state == S_LOAD);
  assign OUT_VALID = (r_state == S_DONE);
  assign ERR       = (r_state == S_DONE) && r_err;

  always_comb begin
    BSEL       = 1'b0;
    CISEL      = 1'b0;
    OSEL       = OSEL_ADDER;
    SHIFT_LA   = 1'b0;
    SHIFT_LR   = 1'b0;
    LOGICAL_OA = 1'b0;
    CSEL       = CSEL_ADDER;
    SHAMT_OUT  = '0;
    ACC_WE     = 1'b0;
    FLAG_WE    = 1'b0;
    if (r_state == S_EXEC) begin
      ACC_WE  = 1'b1;
      FLAG_WE = w_last;
      case (r_fs)
        FS_SUB: begin
          BSEL  = 1'b1;
          CISEL = 1'b1;
        end
        FS_SRA: begin
          OSEL     = OSEL_SHIFT;
          SHIFT_LA = 1'b1;
          SHIFT_LR = 1'b1;
          CSEL     = CSEL_SHIFT;
        end
        FS_SRL: begin
          OSEL     = OSEL_SHIFT;
          SHIFT_LR = 1'b1;
          CSEL     = CSEL_SHIFT;
        end
        FS_SLL: begin
          OSEL = OSEL_SHIFT;
          CSEL = CSEL_SHIFT;
        end
        FS_AND: begin
          OSEL       = OSEL_LOGIC;
          LOGICAL_OA = 1'b1;
          CSEL       = CSEL_ZERO;
        end
        FS_OR: begin
          OSEL = OSEL_LOGIC;
          CSEL = CSEL_ZERO;
        end
        default: ;
      endcase
      if (w_is_shift) begin
        SHAMT_OUT = w_exec_shamt;
        // A zero-distance shift leaves the accumulator alone but still clears carry.
        if (w_shamt_zero) begin
          ACC_WE  = 1'b0;
          FLAG_WE = 1'b1;
          CSEL    = CSEL_ZERO;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

  localparam int SW = 3;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          IN_VALID = 1'b0;
  logic          IN_READY;
  logic [2:0]    FS = 3'b000;
  logic [SW-1:0] SHAMT = '0;
  logic          BSEL, CISEL, SHIFT_LA, SHIFT_LR, LOGICAL_OA;
  logic [1:0]    OSEL, CSEL;
  logic [SW-1:0] SHAMT_OUT;
  logic          ACC_LOAD, ACC_WE, FLAG_WE, OUT_VALID, ERR;
  logic          OUT_READY = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  alu_op_sequencer #(.DATA_W(8), .SHAMT_W(SW)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .FS(FS), .SHAMT(SHAMT), .BSEL(BSEL), .CISEL(CISEL), .OSEL(OSEL),
    .SHIFT_LA(SHIFT_LA), .SHIFT_LR(SHIFT_LR), .LOGICAL_OA(LOGICAL_OA),
    .CSEL(CSEL), .SHAMT_OUT(SHAMT_OUT), .ACC_LOAD(ACC_LOAD), .ACC_WE(ACC_WE),
    .FLAG_WE(FLAG_WE), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .ERR(ERR)
  );

  // Field order: in_ready acc_load acc_we flag_we out_valid err bsel cisel osel la lr oa csel shamt_out
  function automatic logic [17:0] obs();
    return {IN_READY, ACC_LOAD, ACC_WE, FLAG_WE, OUT_VALID, ERR, BSEL, CISEL,
            OSEL, SHIFT_LA, SHIFT_LR, LOGICAL_OA, CSEL, SHAMT_OUT};
  endfunction

  function automatic logic [17:0] mk(input logic ir, ld, we, fw, ov, er, b, ci,
                                     input logic [1:0] os, input logic la, lr, oa,
                                     input logic [1:0] cs, input logic [SW-1:0] sh);
    return {ir, ld, we, fw, ov, er, b, ci, os, la, lr, oa, cs, sh};
  endfunction

  localparam logic [17:0] V_IDLE = 18'h20000;
  localparam logic [17:0] V_LOAD = 18'h10000;
  localparam logic [17:0] V_DONE = 18'h02000;

  // Drives one op on the next falling edge; returns at the falling edge of cycle 1.
  task automatic send(input logic [2:0] fs, input logic [SW-1:0] sh);
    @(negedge CLK);
    IN_VALID = 1'b1;
    FS = fs;
    SHAMT = sh;
    @(negedge CLK);
    IN_VALID = 1'b0;
    FS = 3'b000;
    SHAMT = '0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if (obs() !== V_IDLE) begin
      errors++;
      $display("FAIL reset_state got=%05h exp=%05h", obs(), V_IDLE);
    end
    RST_N = 1'b1;
    @(negedge CLK);
    checks++;
    if (obs() !== V_IDLE) begin
      errors++;
      $display("FAIL reset_release got=%05h exp=%05h", obs(), V_IDLE);
    end
  endtask

  task automatic test_op(input string name, input logic [2:0] fs, input logic [SW-1:0] sh,
                         input logic b, ci, input logic [1:0] os, input logic la, lr, oa,
                         input logic [1:0] cs, input logic is_shift);
    int n;
    logic [SW-1:0] sho;
    logic [17:0] e;
    n = (is_shift && sh != 0) ? int'(sh) : 1;
    sho = is_shift ? SW'(1) : '0;
`ifdef ALU_SEQ_BARREL_EN
    n = 1;
    sho = is_shift ? sh : '0;
`endif
    send(fs, sh);
    checks++;
    if (obs() !== V_LOAD) begin
      errors++;
      $display("FAIL %s load got=%05h exp=%05h", name, obs(), V_LOAD);
    end
    for (int i = 1; i <= n; i++) begin
      @(negedge CLK);
      e = mk(0, 0, 1, (i == n), 0, 0, b, ci, os, la, lr, oa, cs, sho);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL %s exec%0d got=%05h exp=%05h", name, i, obs(), e);
      end
    end
    @(negedge CLK);
    checks++;
    if (obs() !== V_DONE) begin
      errors++;
      $display("FAIL %s done got=%05h exp=%05h", name, obs(), V_DONE);
    end
    OUT_READY = 1'b1;
    @(negedge CLK);
    OUT_READY = 1'b0;
    checks++;
    if (obs() !== V_IDLE) begin
      errors++;
      $display("FAIL %s idle got=%05h exp=%05h", name, obs(), V_IDLE);
    end
  endtask

  task automatic test_alu_ops();
    test_op("add", 3'b000, 3'd0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0);
    test_op("sub", 3'b001, 3'd0, 1, 1, 2'd0, 0, 0, 0, 2'd0, 0);
    test_op("and", 3'b101, 3'd0, 0, 0, 2'd2, 0, 0, 1, 2'd1, 0);
    test_op("or",  3'b110, 3'd4, 0, 0, 2'd2, 0, 0, 0, 2'd1, 0);
  endtask

  task automatic test_shift_ops();
    test_op("sra5", 3'b010, 3'd5, 0, 0, 2'd1, 1, 1, 0, 2'd2, 1);
    test_op("srl2", 3'b011, 3'd2, 0, 0, 2'd1, 0, 1, 0, 2'd2, 1);
    test_op("sll7", 3'b100, 3'd7, 0, 0, 2'd1, 0, 0, 0, 2'd2, 1);
  endtask

  task automatic test_shamt_zero();
    send(3'b100, 3'd0);
    checks++;
    if (obs() !== V_LOAD) begin
      errors++;
      $display("FAIL sll0 load got=%05h exp=%05h", obs(), V_LOAD);
    end
    @(negedge CLK);
    checks++;
    if ({ACC_LOAD, ACC_WE, FLAG_WE, OUT_VALID, CSEL} !== 6'b001001) begin
      errors++;
      $display("FAIL sll0 exec got=%b exp=001001", {ACC_LOAD, ACC_WE, FLAG_WE, OUT_VALID, CSEL});
    end
    @(negedge CLK);
    checks++;
    if (obs() !== V_DONE) begin
      errors++;
      $display("FAIL sll0 done got=%05h exp=%05h", obs(), V_DONE);
    end
    OUT_READY = 1'b1;
    @(negedge CLK);
    OUT_READY = 1'b0;
  endtask

  task automatic test_illegal();
    send(3'b111, 3'd3);
    checks++;
    if (obs() !== 18'h03000) begin
      errors++;
      $display("FAIL illegal done got=%05h exp=03000", obs());
    end
    OUT_READY = 1'b1;
    @(negedge CLK);
    OUT_READY = 1'b0;
    checks++;
    if (obs() !== V_IDLE) begin
      errors++;
      $display("FAIL illegal idle got=%05h exp=%05h", obs(), V_IDLE);
    end
  endtask

  task automatic test_done_hold();
    send(3'b111, 3'd0);
    IN_VALID = 1'b1;
    FS = 3'b000;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs() !== 18'h03000) begin
        errors++;
        $display("FAIL hold cyc%0d got=%05h exp=03000", i, obs());
      end
      @(negedge CLK);
    end
    checks++;
    if (obs() !== 18'h03000) begin
      errors++;
      $display("FAIL hold final got=%05h exp=03000", obs());
    end
    // Handshake with IN_VALID still high: the pending ADD must wait for IDLE.
    OUT_READY = 1'b1;
    @(negedge CLK);
    OUT_READY = 1'b0;
    checks++;
    if (obs() !== V_IDLE) begin
      errors++;
      $display("FAIL hold bubble got=%05h exp=%05h", obs(), V_IDLE);
    end
    @(negedge CLK);
    IN_VALID = 1'b0;
    checks++;
    if (obs() !== V_LOAD) begin
      errors++;
      $display("FAIL hold next_load got=%05h exp=%05h", obs(), V_LOAD);
    end
    repeat (2) @(negedge CLK);
    checks++;
    if (obs() !== V_DONE) begin
      errors++;
      $display("FAIL hold next_done got=%05h exp=%05h", obs(), V_DONE);
    end
    OUT_READY = 1'b1;
    @(negedge CLK);
    OUT_READY = 1'b0;
  endtask

  task automatic test_reset_midop();
    send(3'b011, 3'd7);
    repeat (3) @(negedge CLK);
`ifdef ALU_SEQ_BARREL_EN
    checks++;
    if (obs() !== V_IDLE) begin
      errors++;
      $display("FAIL midop pre got=%05h exp=%05h", obs(), V_IDLE);
    end
`else
    checks++;
    if (obs() !== mk(0, 0, 1, 0, 0, 0, 0, 0, 2'd1, 0, 1, 0, 2'd2, 3'd1)) begin
      errors++;
      $display("FAIL midop exec3 got=%05h exp=%05h", obs(),
               mk(0, 0, 1, 0, 0, 0, 0, 0, 2'd1, 0, 1, 0, 2'd2, 3'd1));
    end
`endif
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if (obs() !== V_IDLE) begin
      errors++;
      $display("FAIL midop async got=%05h exp=%05h", obs(), V_IDLE);
    end
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if (obs() !== V_IDLE) begin
        errors++;
        $display("FAIL midop after%0d got=%05h exp=%05h", i, obs(), V_IDLE);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_shift_ops();
    test_shamt_zero();
    test_illegal();
    test_done_hold();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
